// File: rtl/gpt_frame_gen_pkg.sv
// gpt_frame_gen_pkg: timing constants shared by the gates-per-trig source
// (gpt_frame_gen) and the downstream gpt timing checker.
//   ST_*     frame FSM state encodings
//   DEF_GPT  default gates per frame
//   DEF_CW   default gate counter width
package gpt_frame_gen_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_TRIG = 2'd2;

  localparam int DEF_GPT = 16;
  localparam int DEF_CW  = 9;

endpackage

// File: rtl/gpt_frame_gen_interval_timer.sv
// gpt_interval_timer: loadable down-counter that paces gate strobes.
//   clk, rst_n  clock / async active-low reset
//   ld_i        reload (asserted on the edge that issues a gate)
//   ival_i      interval in cycles; 0 is clamped to 1
//   due_o       next gate may be issued on the coming edge
// Loaded with I-1 when a gate is issued. due_o is high I-1 cycles later, so
// a gate issued on that edge lands exactly I cycles after the previous one.
// The counter parks at zero, so due_o stays up while the FSM holds off.
module gpt_interval_timer #(
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_i,
  input  logic [IW-1:0] ival_i,
  output logic          due_o
);

  logic [IW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i)             cnt_d = (ival_i == '0) ? '0 : ival_i - 1'b1;
    else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign due_o = (cnt_q == '0);

endmodule

// File: rtl/gpt_frame_gen.sv
// gpt_frame_gen: source of a gates-per-trig stream. Emits `gate` strobes
// every `interval` cycles and a `trig` after every GPT gates.
//   clk, rst_n   clock / async active-low reset
//   start        run request, honoured only when idle
//   abort        level, ends the run without trig or done
//   interval     gate spacing (0 acts as 1), sampled at start
//   frames       frame count (0 = free-running), sampled at start
//   gate, trig   strobes (never together)
//   busy         high while running (RUN / TRIG)
//   done         one-cycle pulse after the final trig of a finite run
//   frame_cnt    trigs since start, saturating
// Optional macro GPT_FRAME_GEN_ERRINJ_EN adds inj_extra / inj_miss inputs
// that stretch the current frame to GPT+1 gates or shrink it to GPT-1.
module gpt_frame_gen
  import gpt_frame_gen_pkg::*;
#(
  parameter int GPT = DEF_GPT,
  parameter int CW  = DEF_CW,
  parameter int IW  = 8,
  parameter int FW  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [IW-1:0] interval,
  input  logic [FW-1:0] frames,
`ifdef GPT_FRAME_GEN_ERRINJ_EN
  input  logic          inj_extra,
  input  logic          inj_miss,
`endif
  output logic          gate,
  output logic          trig,
  output logic          busy,
  output logic          done,
  output logic [FW-1:0] frame_cnt
);

  localparam logic [CW-1:0] GPT_C = CW'(GPT);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] ival_q, ival_d, ld_val;
  logic [FW-1:0] frames_q, frames_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [CW-1:0] gcnt_q, gcnt_d;
  logic [CW-1:0] tgt;
  logic          gate_q, gate_d, trig_q, trig_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          due;

  gpt_interval_timer #(.IW(IW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld_i   (gate_d),
    .ival_i (ld_val),
    .due_o  (due)
  );

`ifdef GPT_FRAME_GEN_ERRINJ_EN
  // Requests stick until the frame's trig; leaving RUN drops them.
  logic ext_q, mis_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      ext_q <= (state_q == ST_RUN) && (ext_q || inj_extra);
      mis_q <= (state_q == ST_RUN) && (mis_q || inj_miss);
    end
  end
  // Extra wins; a shortened frame never drops below one gate.
  always_comb begin
    tgt = GPT_C;
    if (ext_q)                tgt = GPT_C + 1'b1;
    else if (mis_q && GPT > 1) tgt = GPT_C - 1'b1;
  end
`else
  assign tgt = GPT_C;
`endif

  // gcnt counts gates already issued, including the one on the output now,
  // so the frame closes on the edge right after its last gate.
  always_comb begin
    state_d  = state_q;
    ival_d   = ival_q;
    frames_d = frames_q;
    fcnt_d   = fcnt_q;
    gcnt_d   = gcnt_q;
    gate_d   = 1'b0;
    trig_d   = 1'b0;
    done_d   = 1'b0;
    ld_val   = ival_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d  = ST_RUN;
          ival_d   = interval;
          frames_d = frames;
          fcnt_d   = '0;
          gcnt_d   = CW'(1);
          gate_d   = 1'b1;
          ld_val   = interval;   // latched copy not valid yet
        end
      end
      ST_RUN: begin
        // Gate must be on the output now so trig always follows a gate.
        if (gate_q && gcnt_q >= tgt) begin
          state_d = ST_TRIG;
          trig_d  = 1'b1;
          gcnt_d  = '0;
          fcnt_d  = (&fcnt_q) ? fcnt_q : fcnt_q + 1'b1;
        end else if (due) begin
          gate_d = 1'b1;
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      ST_TRIG: begin
        if (frames_q != '0 && fcnt_q == frames_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
          // Timer kept running through TRIG: gate lands at
          // max(last gate + interval, trig + 1).
          if (due) begin
            gate_d = 1'b1;
            gcnt_d = CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      gate_d  = 1'b0;
      trig_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign busy_d = (state_d != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ival_q   <= '0;
      frames_q <= '0;
      fcnt_q   <= '0;
      gcnt_q   <= '0;
      gate_q   <= 1'b0;
      trig_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ival_q   <= ival_d;
      frames_q <= frames_d;
      fcnt_q   <= fcnt_d;
      gcnt_q   <= gcnt_d;
      gate_q   <= gate_d;
      trig_q   <= trig_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign gate      = gate_q;
  assign trig      = trig_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_gpt_frame_gen.sv
// tb_gpt_frame_gen: directed, table-driven bench for gpt_frame_gen (GPT=16).
// Cycle numbers are relative to the cycle in which start is high (cycle 0).
module tb_gpt_frame_gen;

  localparam int GPT = 16;
  localparam int IW  = 8;
  localparam int FW  = 16;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [IW-1:0] interval = '0;
  logic [FW-1:0] frames = '0;
  logic          gate, trig, busy, done;
  logic [FW-1:0] frame_cnt;
`ifdef GPT_FRAME_GEN_ERRINJ_EN
  logic          inj_extra = 1'b0, inj_miss = 1'b0;
  int            inj_x_cyc = -1, inj_m_cyc = -1;
`endif

  int checks = 0, errors = 0;
  int pc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) pc <= pc + 1;

  gpt_frame_gen #(.GPT(GPT), .CW(9), .IW(IW), .FW(FW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .interval  (interval),
    .frames    (frames),
`ifdef GPT_FRAME_GEN_ERRINJ_EN
    .inj_extra (inj_extra),
    .inj_miss  (inj_miss),
`endif
    .gate      (gate),
    .trig      (trig),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Results of the last run_vec
  int r_trig1, r_last_trig, r_done, r_fc, r_gates, r_bad, r_ntrig, r_busy_done;
  int fg[8];
  logic [2:0] r_ab_out;

  // Start a run and monitor it until done, stop_trigs trigs, or an abort
  // issued on gate number ab_gate of frame ab_frame.
  task automatic run_vec(input int iv, input int fr, input int stop_trigs,
                         input int ab_frame, input int ab_gate);
    int p0, c, fgc;
    logic pg;
    r_trig1 = -1; r_last_trig = -1; r_done = -1; r_fc = -1;
    r_gates = 0; r_bad = 0; r_ntrig = 0; r_busy_done = -1; r_ab_out = '1;
    foreach (fg[i]) fg[i] = 0;
    fgc = 0; pg = 1'b0;
    @(negedge clk);
    interval = IW'(iv); frames = FW'(fr); start = 1'b1; p0 = pc;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      start = 1'b0;
      c = pc - p0;
`ifdef GPT_FRAME_GEN_ERRINJ_EN
      inj_extra = (c == inj_x_cyc);
      inj_miss  = (c == inj_m_cyc);
`endif
      if (gate) begin r_gates++; fgc++; end
      if (gate && trig) r_bad++;
      if (trig) begin
        if (!pg) r_bad++;
        if (fgc != GPT) r_bad++;
        if (r_ntrig < 8) fg[r_ntrig] = fgc;
        fgc = 0;
        if (r_trig1 < 0) r_trig1 = c;
        r_last_trig = c;
        r_ntrig++;
      end
      pg = gate;
      if (done) begin
        r_done = c; r_fc = int'(frame_cnt); r_busy_done = int'(busy);
        break;
      end
      if (stop_trigs > 0 && r_ntrig == stop_trigs) break;
      if (ab_gate > 0 && gate && r_ntrig == ab_frame - 1 && fgc == ab_gate) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        r_ab_out = {gate, trig, busy};
        break;
      end
    end
    if (r_fc < 0) r_fc = int'(frame_cnt);
`ifdef GPT_FRAME_GEN_ERRINJ_EN
    inj_extra = 1'b0; inj_miss = 1'b0;
`endif
  endtask

  typedef struct {
    int iv, fr;
    int exp_trig1, exp_done, exp_fc, exp_gates;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    vecs[0] = '{3,   2, 47,   96,   2, 32};
    vecs[1] = '{1,   5, 17,   86,   5, 80};
    vecs[2] = '{0,   5, 17,   86,   5, 80};
    vecs[3] = '{2,   1, 32,   33,   1, 16};
    vecs[4] = '{2,   3, 32,   97,   3, 48};
    vecs[5] = '{5,   1, 77,   78,   1, 16};
    vecs[6] = '{255, 1, 3827, 3828, 1, 16};

    // Reset state
    @(negedge clk);
    chk("reset_outputs", int'({gate, trig, busy, done, frame_cnt}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_release", int'({gate, trig, busy, done}), 0);

    // Table of finite runs
    foreach (vecs[i]) begin
      run_vec(vecs[i].iv, vecs[i].fr, 0, 0, 0);
      chk($sformatf("v%0d_first_trig", i), r_trig1, vecs[i].exp_trig1);
      chk($sformatf("v%0d_done_cycle", i), r_done, vecs[i].exp_done);
      chk($sformatf("v%0d_frame_cnt", i), r_fc, vecs[i].exp_fc);
      chk($sformatf("v%0d_gates", i), r_gates, vecs[i].exp_gates);
      chk($sformatf("v%0d_frame_violations", i), r_bad, 0);
      chk($sformatf("v%0d_busy_at_done", i), r_busy_done, 0);
      repeat (2) @(negedge clk);
    end

    // Free-running, interval 1: trig every 17 cycles, then abort
    run_vec(1, 0, 5, 0, 0);
    chk("free_first_trig", r_trig1, 17);
    chk("free_fifth_trig", r_last_trig, 85);
    chk("free_violations", r_bad, 0);
    chk("free_busy", int'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("free_abort_out", int'({gate, trig, busy, done}), 0);
    chk("free_abort_fcnt", int'(frame_cnt), 5);

    // Abort on the 10th gate of frame 2
    repeat (2) @(negedge clk);
    run_vec(3, 0, 0, 2, 10);
    chk("abort_out_next_cycle", int'(r_ab_out), 0);
    chk("abort_frame_cnt", r_fc, 1);
    chk("abort_trigs_before", r_ntrig, 1);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (gate || trig || done || busy) n++;
    end
    chk("abort_quiet_after", n, 0);

    // Async reset mid-frame, then a fresh run
    @(negedge clk);
    interval = 8'd2; frames = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      if (gate) n++;
      if (n < 4) @(negedge clk);
    end
    chk("pre_reset_gate", int'({gate, busy}), 3);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_out", int'({gate, trig, busy, done, frame_cnt}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (gate || busy) n++;
    end
    chk("no_resume_after_reset", n, 0);
    run_vec(2, 1, 0, 0, 0);
    chk("post_reset_trig", r_trig1, 32);
    chk("post_reset_gates", r_gates, 16);
    chk("post_reset_done", r_done, 33);

`ifdef GPT_FRAME_GEN_ERRINJ_EN
    // Extra gate in frame 1; frame 2 clean
    repeat (2) @(negedge clk);
    inj_x_cyc = 3; inj_m_cyc = -1;
    run_vec(2, 2, 0, 0, 0);
    chk("inj_extra_f1", fg[0], 17);
    chk("inj_extra_f2", fg[1], 16);
    // Missing gate in frame 1; frame 2 clean
    repeat (2) @(negedge clk);
    inj_x_cyc = -1; inj_m_cyc = 3;
    run_vec(2, 2, 0, 0, 0);
    chk("inj_miss_f1", fg[0], 15);
    chk("inj_miss_f2", fg[1], 16);
    inj_m_cyc = -1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
